// File: rtl/axis_tg_ctrl_if.sv
// Generator-facing bus of the traffic-generator run controller: config broadcast,
// start pulse, and per-generator done / sent counts plus the aggregate sink count.
interface axis_tg_ctrl_if #(
  parameter int NUM_TG      = 4,
  parameter int COUNT_WIDTH = 32
);
  localparam int SUM_W = COUNT_WIDTH + $clog2(NUM_TG) + 1;

  logic [15:0]                   tg_load;
  logic [COUNT_WIDTH-1:0]        tg_num_packets;
  logic                          tg_start;
  logic [NUM_TG-1:0]             tg_done;
  logic [NUM_TG*COUNT_WIDTH-1:0] tg_sent_total;
  logic [SUM_W-1:0]              rx_total;

  modport master (output tg_load, tg_num_packets, tg_start,
                  input  tg_done, tg_sent_total, rx_total);
  modport slave  (input  tg_load, tg_num_packets, tg_start,
                  output tg_done, tg_sent_total, rx_total);
endinterface

// File: rtl/axis_tg_ctrl.sv
// Run controller for the AXI-Stream traffic-generator harness.
// Optional run timeout is built only when TG_CTRL_TIMEOUT_EN is defined.
module axis_tg_ctrl #(
  parameter int NUM_TG        = 4,
  parameter int COUNT_WIDTH   = 32,
  parameter int TICK_WIDTH    = 256,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_start,
  input  logic                   cmd_abort,
  input  logic [15:0]            cfg_load,
  input  logic [COUNT_WIDTH-1:0] cfg_num_packets,
  input  logic [COUNT_WIDTH-1:0] cfg_timeout,
  axis_tg_ctrl_if.master         tg,
  output logic [TICK_WIDTH-1:0]  ticks,
  output logic                   busy,
  output logic                   run_done,
  output logic                   timed_out,
  output logic [COUNT_WIDTH-1:0] run_cycles
);
  localparam int SUM_W = COUNT_WIDTH + $clog2(NUM_TG) + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, START, ACK, RUN, DRAIN} state_t;

  state_t           state, state_nx;
  logic [SET_W-1:0] settle_cnt;
  logic [SUM_W-1:0] sent_sum, sent_next;
  logic             drain_first;
  logic             accept, abort, done_hit, tmo_hit, in_run;

  assign busy        = (state != IDLE);
  assign tg.tg_start = (state == START);
  assign in_run      = (state == RUN) || (state == DRAIN);
  assign accept      = (state == IDLE) && cmd_start;
  assign abort       = (state != IDLE) && cmd_abort;
  // sent_sum lags by a cycle, so the first DRAIN cycle is never compared
  assign done_hit    = (state == DRAIN) && !drain_first && (tg.rx_total == sent_sum);

  always_comb begin
    sent_next = '0;
    for (int i = 0; i < NUM_TG; i++)
      sent_next = sent_next + SUM_W'(tg.tg_sent_total[i*COUNT_WIDTH +: COUNT_WIDTH]);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_start) state_nx = SETTLE;
      SETTLE:  if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) state_nx = START;
      START:   state_nx = ACK;
      ACK:     state_nx = RUN;
      RUN:     if (&tg.tg_done) state_nx = DRAIN;
      DRAIN:   state_nx = DRAIN;
      default: state_nx = IDLE;
    endcase
    if (abort || done_hit || tmo_hit) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      settle_cnt        <= '0;
      sent_sum          <= '0;
      drain_first       <= 1'b0;
      tg.tg_load        <= '0;
      tg.tg_num_packets <= '0;
      run_done          <= 1'b0;
      run_cycles        <= '0;
      ticks             <= '0;
    end else begin
      state       <= state_nx;
      ticks       <= ticks + TICK_WIDTH'(1);
      sent_sum    <= sent_next;
      drain_first <= (state == RUN);
      run_done    <= done_hit && !abort;
      if (state == SETTLE) settle_cnt <= settle_cnt + SET_W'(1);
      if (in_run && !abort && run_cycles != '1) run_cycles <= run_cycles + COUNT_WIDTH'(1);
      if (accept) begin
        tg.tg_load        <= cfg_load;
        tg.tg_num_packets <= cfg_num_packets;
        run_cycles        <= '0;
        settle_cnt        <= '0;
      end
      // zero load makes generators stop injecting immediately
      if (abort) tg.tg_load <= '0;
    end
  end

`ifdef TG_CTRL_TIMEOUT_EN
  logic [COUNT_WIDTH-1:0] timeout_q;
  logic [COUNT_WIDTH:0]   rc_inc;

  assign rc_inc  = {1'b0, run_cycles} + {{COUNT_WIDTH{1'b0}}, 1'b1};
  assign tmo_hit = in_run && (timeout_q != '0) && (rc_inc == {1'b0, timeout_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= '0;
      timed_out <= 1'b0;
    end else if (accept) begin
      timeout_q <= cfg_timeout;
      timed_out <= 1'b0;
    end else if (tmo_hit && !done_hit && !abort) begin
      timed_out <= 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^cfg_timeout;
  assign tmo_hit    = 1'b0;
  assign timed_out  = 1'b0;
`endif
endmodule

// File: tb/tb_axis_tg_ctrl.sv
// Randomized run-level bench for axis_tg_ctrl with a cycle-accurate generator/sink model.
module tb_axis_tg_ctrl;
  localparam int NTG = 4, CW = 32, TW = 256, SC = 16;
  localparam int SW  = CW + $clog2(NTG) + 1;
  localparam int EV_DONE = 0, EV_TMO = 1, EV_ABORT = 2, EV_RST = 3;
  localparam int NEVER = 1 << 30;
`ifdef TG_CTRL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1, cmd_start = 1'b0, cmd_abort = 1'b0;
  logic [15:0]          cfg_load = '0;
  logic [CW-1:0]        cfg_num_packets = '0, cfg_timeout = '0;
  logic [TW-1:0]        ticks;
  logic                 busy, run_done, timed_out;
  logic [CW-1:0]        run_cycles;

  axis_tg_ctrl_if #(.NUM_TG(NTG), .COUNT_WIDTH(CW)) tgb();

  axis_tg_ctrl #(.NUM_TG(NTG), .COUNT_WIDTH(CW), .TICK_WIDTH(TW), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cfg_load(cfg_load), .cfg_num_packets(cfg_num_packets), .cfg_timeout(cfg_timeout),
    .tg(tgb), .ticks(ticks), .busy(busy), .run_done(run_done),
    .timed_out(timed_out), .run_cycles(run_cycles));

  int          n_chk = 0, n_fail = 0, cyc = 0;
  logic [TW-1:0] exp_ticks = '0;
  // generator/sink model: start seen in cycle g_s, generator i busy for g_d[i] cycles
  int          g_s = -1, g_dmax = 1, g_r = 0, g_never = 0;
  int          g_d[NTG];
  logic [CW-1:0] g_num = '0;

  task automatic tick();
    @(posedge clk);
    exp_ticks = rst ? '0 : exp_ticks + TW'(1);
    #1;
    cyc++;
  endtask

  task automatic drive_gen();
    logic [SW-1:0] full;
    full = '0;
    for (int i = 0; i < NTG; i++) begin
      full = full + SW'(g_num);
      if (g_s < 0 || cyc <= g_s) begin
        tgb.tg_done[i] = 1'b1;
        tgb.tg_sent_total[i*CW +: CW] = '0;
      end else if (g_never == 0 && cyc > g_s + g_d[i]) begin
        tgb.tg_done[i] = 1'b1;
        tgb.tg_sent_total[i*CW +: CW] = g_num;
      end else begin
        tgb.tg_done[i] = 1'b0;
        tgb.tg_sent_total[i*CW +: CW] = '0;
      end
    end
    if (g_s < 0 || cyc <= g_s) tgb.rx_total = '0;
    else if (g_never == 0 && cyc >= g_s + g_dmax + 1 + g_r) tgb.rx_total = full;
    else tgb.rx_total = full - SW'(1);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      n_chk++;
      if (busy !== 1'b0 || tgb.tg_start !== 1'b0 || run_done !== 1'b0 || ticks !== exp_ticks) begin
        n_fail++;
        $display("FAIL idle cyc=%0d busy=%0b start=%0b done=%0b ticks=%0d exp_ticks=%0d",
                 cyc, busy, tgb.tg_start, run_done, ticks, exp_ticks);
      end
      tick();
    end
  endtask

  // One run from cmd_start to its end event; end event and its cycle are derived from the rules:
  // start in k0+1+SC, RUN from s+2, all done in c, completion in first k>=c+2 where rx matches.
  task automatic do_run(input logic [15:0] ld, input logic [CW-1:0] num, input logic [CW-1:0] tmo,
                        input int dmax, input int r, input int never,
                        input int abort_off, input int rst_off, input logic with_abort);
    int s, c, d, f, a, rs, e, ev;
    logic [CW-1:0] exp_rc, exp_ld, exp_num;
    s = cyc + 1 + SC;
    c = s + dmax + 1;
    d = never ? NEVER : c + ((r > 2) ? r : 2);
    f = (TMO_EN && tmo != '0) ? s + 1 + int'(tmo) : NEVER;
    a = (abort_off >= 0) ? s + 2 + abort_off : NEVER;
    rs = (rst_off >= 0) ? c + 1 + rst_off : NEVER;
    e = d; ev = EV_DONE;
    if (f < e)   begin e = f;  ev = EV_TMO;   end
    if (a <= e)  begin e = a;  ev = EV_ABORT; end
    if (rs <= e) begin e = rs; ev = EV_RST;   end
    g_dmax = dmax; g_r = r; g_never = never; g_num = num;
    for (int i = 0; i < NTG; i++) g_d[i] = 1 + int'($urandom_range(dmax - 1));
    g_d[$urandom_range(NTG - 1)] = dmax;
    cmd_start = 1'b1; cmd_abort = with_abort;
    cfg_load = ld; cfg_num_packets = num; cfg_timeout = tmo;
    tick();
    g_s = s;
    cmd_start = 1'b0;
    forever begin
      cmd_abort = (cyc == a);
      rst = (cyc == rs);
      drive_gen();
      n_chk++;
      if (busy !== (cyc <= e) || tgb.tg_start !== (cyc == s && cyc <= e)) begin
        n_fail++;
        $display("FAIL ctl cyc=%0d busy=%0b start=%0b exp_busy=%0b exp_start=%0b",
                 cyc, busy, tgb.tg_start, cyc <= e, cyc == s);
      end
      n_chk++;
      if (run_done !== (cyc == e + 1 && ev == EV_DONE) || ticks !== exp_ticks) begin
        n_fail++;
        $display("FAIL run_done/ticks cyc=%0d done=%0b ticks=%0d exp_ticks=%0d",
                 cyc, run_done, ticks, exp_ticks);
      end
      if (cyc <= e) begin
        exp_rc = (cyc >= s + 2) ? CW'(cyc - s - 2) : '0;
        n_chk++;
        if (tgb.tg_load !== ld || tgb.tg_num_packets !== num || timed_out !== 1'b0 || run_cycles !== exp_rc) begin
          n_fail++;
          $display("FAIL in_run cyc=%0d load=%h/%h num=%0d/%0d tmo=%0b rc=%0d/%0d",
                   cyc, tgb.tg_load, ld, tgb.tg_num_packets, num, timed_out, run_cycles, exp_rc);
        end
      end
      if (cyc == e + 1) break;
      tick();
    end
    case (ev)
      EV_DONE:  exp_rc = CW'(d - s - 1);
      EV_TMO:   exp_rc = tmo;
      EV_ABORT: exp_rc = (a >= s + 2) ? CW'(a - s - 2) : '0;
      default:  exp_rc = '0;
    endcase
    exp_ld  = (ev == EV_ABORT || ev == EV_RST) ? '0 : CW'(ld);
    exp_num = (ev == EV_RST) ? '0 : num;
    n_chk++;
    if (run_cycles !== exp_rc || timed_out !== (ev == EV_TMO) || CW'(tgb.tg_load) !== exp_ld ||
        tgb.tg_num_packets !== exp_num) begin
      n_fail++;
      $display("FAIL end ev=%0d rc=%0d exp=%0d tmo=%0b load=%h exp=%h num=%0d exp=%0d",
               ev, run_cycles, exp_rc, timed_out, tgb.tg_load, exp_ld, tgb.tg_num_packets, exp_num);
    end
    rst = 1'b0; cmd_abort = 1'b0; g_s = -1;
    drive_gen();
    tick();
    idle(4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_gen();
    repeat (3) tick();
    n_chk++;
    if (busy !== 0 || tgb.tg_start !== 0 || tgb.tg_load !== '0 || tgb.tg_num_packets !== '0 ||
        run_done !== 0 || timed_out !== 0 || run_cycles !== '0 || ticks !== '0) begin
      n_fail++;
      $display("FAIL reset busy=%0b start=%0b load=%h num=%0d done=%0b tmo=%0b rc=%0d ticks=%0d exp all zero",
               busy, tgb.tg_start, tgb.tg_load, tgb.tg_num_packets, run_done, timed_out, run_cycles, ticks);
    end
    rst = 1'b0;
    tick();
    n_chk++;
    if (ticks !== TW'(1)) begin n_fail++; $display("FAIL ticks_after_reset got=%0d exp=1", ticks); end
  endtask

  task automatic test_basic();
    while (cyc < 10) idle(1);
    do_run(16'h8000, 100, 0, 50, 10, 0, -1, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++)
      do_run(16'($urandom), CW'($urandom_range(1000, 1)), 0,
             int'($urandom_range(40, 1)), int'($urandom_range(15)), 0, -1, -1, 1'b0);
  endtask

  task automatic test_timeout();
    do_run(16'h1234, 50, 20, 1, 0, 1, 40, -1, 1'b0);
    do_run(16'h4321, 7, 0, 5, 3, 0, -1, -1, 1'b0);
  endtask

  task automatic test_abort();
    do_run(16'hffff, 30, 0, 30, 4, 0, 5, -1, 1'b0);
    do_run(16'h0101, 9, 0, 6, 1, 0, -1, -1, 1'b1);
  endtask

  task automatic test_tmo_collide();
    do_run(16'h0f0f, 12, CW'(10 + 1 + 5 - 1), 10, 5, 0, -1, -1, 1'b0);
    do_run(16'h00ff, 3, CW'(8 + 1 + 2 - 1), 8, 0, 0, -1, -1, 1'b0);
  endtask

  task automatic test_reset_drain();
    do_run(16'haaaa, 20, 0, 20, 30, 0, -1, 3, 1'b0);
    n_chk++;
    if (ticks !== exp_ticks || exp_ticks > TW'(10)) begin
      n_fail++;
      $display("FAIL ticks_restart got=%0d exp=%0d", ticks, exp_ticks);
    end
  endtask

  task automatic test_back_to_back();
    do_run(16'h0001, 1, 0, 1, 0, 0, -1, -1, 1'b0);
    do_run(16'h0002, 2, 0, 2, 2, 0, -1, -1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NTG; i++) g_d[i] = 1;
    test_reset();
    test_basic();
    test_random();
    test_timeout();
    test_abort();
    test_tmo_collide();
    test_reset_drain();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d exp=finish before time limit", cyc);
    $fatal(1, "watchdog");
  end
endmodule
